// File: rtl/nemu_run_controller.sv
// Run sequencer for a NEMU emulation: phase FSM, shared timestamp, and
// injection/delivery accounting across all packet sources and sinks.
module nemu_run_controller #(
  parameter int PORTS          = 16,
  parameter int WARMUP_CYCLES  = 600,
  parameter int MEASURE_CYCLES = 10000,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [PORTS-1:0] i_src_valid,
  input  logic [PORTS-1:0] i_src_empty,
  input  logic [PORTS-1:0] i_sink_valid,
  output logic [31:0]      o_timestamp,
  output logic             o_src_enable,
  output logic             o_measure,
  output logic [2:0]       o_state,
  output logic [31:0]      o_inj_count,
  output logic [31:0]      o_rx_count,
  output logic [31:0]      o_outstanding,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [31:0] phase_cnt;
  logic [31:0] src_cnt, sink_cnt;
  logic [32:0] out_sum;
  logic        underflow;
  logic [31:0] out_next;
  logic        drain_exit;
  logic        go_start, phase_clr, timeout_set, running;

  function automatic logic [31:0] popcount(input logic [PORTS-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < PORTS; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Traffic accounting; a delivery surplus clamps outstanding at zero
  assign src_cnt    = popcount(i_src_valid);
  assign sink_cnt   = popcount(i_sink_valid);
  assign out_sum    = {1'b0, o_outstanding} + {1'b0, src_cnt};
  assign underflow  = out_sum < {1'b0, sink_cnt};
  assign out_next   = underflow ? 32'd0 : 32'(out_sum - {1'b0, sink_cnt});
  assign drain_exit = (o_outstanding == 32'd0) && (&i_src_empty);
  assign running    = (state == S_WARMUP) || (state == S_MEASURE) || (state == S_DRAIN);

  always_comb begin
    state_nx    = state;
    go_start    = 1'b0;
    phase_clr   = 1'b0;
    timeout_set = 1'b0;
    if (i_abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_nx = S_WARMUP;
            go_start = 1'b1;
          end
        end
        S_WARMUP: begin
          if (phase_cnt == 32'(WARMUP_CYCLES - 1)) begin
            state_nx  = S_MEASURE;
            phase_clr = 1'b1;
          end
        end
        S_MEASURE: begin
          if (phase_cnt == 32'(MEASURE_CYCLES - 1)) begin
            state_nx  = S_DRAIN;
            phase_clr = 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state_nx = S_DONE;
          end else if (phase_cnt == 32'(DRAIN_TIMEOUT - 1)) begin
            state_nx    = S_DONE;
            timeout_set = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      phase_cnt     <= '0;
      o_timestamp   <= '0;
      o_inj_count   <= '0;
      o_rx_count    <= '0;
      o_outstanding <= '0;
      o_timeout     <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state <= state_nx;
      if (go_start) begin
        phase_cnt     <= '0;
        o_timestamp   <= '0;
        o_inj_count   <= '0;
        o_rx_count    <= '0;
        o_outstanding <= '0;
        o_timeout     <= 1'b0;
        o_error       <= 1'b0;
      end else if (running && !i_abort) begin
        // An abort cycle leaves every counter exactly as it was
        o_timestamp   <= o_timestamp + 32'd1;
        phase_cnt     <= phase_clr ? 32'd0 : phase_cnt + 32'd1;
        o_outstanding <= out_next;
        if (underflow)   o_error   <= 1'b1;
        if (timeout_set) o_timeout <= 1'b1;
        if (state == S_MEASURE) begin
          o_inj_count <= o_inj_count + src_cnt;
          o_rx_count  <= o_rx_count + sink_cnt;
        end
      end
    end
  end

  assign o_state      = state;
  assign o_src_enable = (state == S_WARMUP) || (state == S_MEASURE);
  assign o_measure    = (state == S_MEASURE);
  assign o_done       = (state == S_DONE);

endmodule

// File: tb/tb_nemu_run_controller.sv
// Scoreboard bench for nemu_run_controller: stimulus queues expected output
// values per cycle, a negedge monitor pops and compares them.
module tb_nemu_run_controller;
  localparam int PORTS = 4;

  localparam int SIG_STATE = 0, SIG_TS = 1, SIG_INJ = 2, SIG_RX = 3, SIG_OUT = 4;
  localparam int SIG_DONE = 5, SIG_TO = 6, SIG_ERR = 7, SIG_SRCEN = 8, SIG_MEAS = 9;

  logic             i_clk = 1'b0;
  logic             reset_n, i_start, i_abort;
  logic [PORTS-1:0] i_src_valid, i_src_empty, i_sink_valid;
  logic [31:0]      o_timestamp, o_inj_count, o_rx_count, o_outstanding;
  logic             o_src_enable, o_measure, o_done, o_timeout, o_error;
  logic [2:0]       o_state;

  nemu_run_controller #(
    .PORTS(PORTS), .WARMUP_CYCLES(4), .MEASURE_CYCLES(8), .DRAIN_TIMEOUT(16)
  ) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_src_valid(i_src_valid), .i_src_empty(i_src_empty), .i_sink_valid(i_sink_valid),
    .o_timestamp(o_timestamp), .o_src_enable(o_src_enable), .o_measure(o_measure),
    .o_state(o_state), .o_inj_count(o_inj_count), .o_rx_count(o_rx_count),
    .o_outstanding(o_outstanding), .o_done(o_done), .o_timeout(o_timeout),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  function automatic logic [31:0] dut_val(input int sig);
    case (sig)
      SIG_STATE: return {29'd0, o_state};
      SIG_TS:    return o_timestamp;
      SIG_INJ:   return o_inj_count;
      SIG_RX:    return o_rx_count;
      SIG_OUT:   return o_outstanding;
      SIG_DONE:  return {31'd0, o_done};
      SIG_TO:    return {31'd0, o_timeout};
      SIG_ERR:   return {31'd0, o_error};
      SIG_SRCEN: return {31'd0, o_src_enable};
      SIG_MEAS:  return {31'd0, o_measure};
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: checks every expectation tagged for the current cycle
  initial forever begin
    exp_t        e;
    logic [31:0] act;
    @(negedge i_clk);
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      act = dut_val(e.sig);
      n_chk++;
      if (act !== e.val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.cyc);
      end
    end
  end

  task automatic expect_val(input int sig, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] k);
    i_src_valid  = s;
    i_sink_valid = k;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    drive(4'h0, 4'h0);
    i_src_empty = 4'hF;
    ticks(2);
    expect_val(SIG_STATE, 0, "rst_state");
    expect_val(SIG_TS, 0, "rst_ts");
    expect_val(SIG_INJ, 0, "rst_inj");
    expect_val(SIG_OUT, 0, "rst_out");
    expect_val(SIG_DONE, 0, "rst_done");
    expect_val(SIG_SRCEN, 0, "rst_srcen");
    reset_n = 1'b1;
    tick();
    expect_val(SIG_STATE, 0, "idle_after_rst");

    // Nominal run: 2 packets per MEASURE cycle, echoed two cycles later
    do_start();
    expect_val(SIG_STATE, 1, "nom_warmup");
    expect_val(SIG_TS, 0, "nom_ts0");
    expect_val(SIG_SRCEN, 1, "nom_srcen");
    expect_val(SIG_MEAS, 0, "nom_meas0");
    ticks(3);
    expect_val(SIG_STATE, 1, "nom_warmup_last");
    expect_val(SIG_TS, 3, "nom_ts3");
    tick();
    expect_val(SIG_STATE, 2, "nom_measure");
    expect_val(SIG_TS, 4, "nom_measure_ts");
    expect_val(SIG_MEAS, 1, "nom_meas1");
    for (int j = 0; j <= 10; j++) begin
      drive((j < 8) ? 4'h3 : 4'h0, (j >= 2 && j < 10) ? 4'h3 : 4'h0);
      tick();
      if (j == 7) begin
        expect_val(SIG_STATE, 3, "nom_drain");
        expect_val(SIG_TS, 12, "nom_drain_ts");
        expect_val(SIG_INJ, 16, "nom_inj");
        expect_val(SIG_RX, 12, "nom_rx");
        expect_val(SIG_OUT, 4, "nom_out_drain");
        expect_val(SIG_SRCEN, 0, "nom_srcen_drain");
      end
      if (j == 9) begin
        expect_val(SIG_STATE, 3, "nom_drain2");
        expect_val(SIG_OUT, 0, "nom_out0");
      end
      if (j == 10) begin
        expect_val(SIG_STATE, 4, "nom_done_state");
        expect_val(SIG_DONE, 1, "nom_done");
        expect_val(SIG_TO, 0, "nom_timeout");
        expect_val(SIG_TS, 15, "nom_done_ts");
      end
    end
    drive(4'h0, 4'h0);
    tick();
    expect_val(SIG_TS, 15, "nom_ts_frozen");
    expect_val(SIG_INJ, 16, "nom_inj_frozen");
    expect_val(SIG_RX, 12, "nom_rx_frozen");

    // Restart from DONE, then drain timeout with 3 undelivered packets
    do_start();
    expect_val(SIG_STATE, 1, "rs_warmup");
    expect_val(SIG_TS, 0, "rs_ts");
    expect_val(SIG_INJ, 0, "rs_inj");
    expect_val(SIG_RX, 0, "rs_rx");
    expect_val(SIG_DONE, 0, "rs_done");
    ticks(4);
    drive(4'h7, 4'h0);
    tick();
    drive(4'h0, 4'h0);
    ticks(7);
    expect_val(SIG_STATE, 3, "to_drain");
    expect_val(SIG_INJ, 3, "to_inj");
    expect_val(SIG_OUT, 3, "to_out");
    ticks(15);
    expect_val(SIG_STATE, 3, "to_still_drain");
    expect_val(SIG_TO, 0, "to_not_yet");
    tick();
    expect_val(SIG_STATE, 4, "to_done_state");
    expect_val(SIG_TO, 1, "to_timeout");
    expect_val(SIG_DONE, 1, "to_done");
    expect_val(SIG_OUT, 3, "to_out_final");
    expect_val(SIG_TS, 28, "to_ts");

    // FIFO gating, with traffic on the last WARMUP and last MEASURE cycles
    do_start();
    expect_val(SIG_TO, 0, "fg_timeout_clr");
    expect_val(SIG_OUT, 0, "fg_out_clr");
    ticks(3);
    drive(4'h1, 4'h1);
    tick();
    expect_val(SIG_STATE, 2, "fg_measure");
    expect_val(SIG_INJ, 0, "fg_warmup_not_counted");
    expect_val(SIG_RX, 0, "fg_warmup_rx_not_counted");
    drive(4'h0, 4'h0);
    ticks(7);
    drive(4'h1, 4'h1);
    i_src_empty = 4'hE;
    tick();
    expect_val(SIG_STATE, 3, "fg_drain");
    expect_val(SIG_INJ, 1, "fg_last_measure_inj");
    expect_val(SIG_RX, 1, "fg_last_measure_rx");
    drive(4'h0, 4'h0);
    ticks(5);
    expect_val(SIG_STATE, 3, "fg_gated");
    i_src_empty = 4'hF;
    tick();
    expect_val(SIG_STATE, 4, "fg_done");
    expect_val(SIG_TS, 18, "fg_ts");
    expect_val(SIG_TO, 0, "fg_timeout");

    // Underflow in WARMUP, then minimum-length DRAIN
    do_start();
    drive(4'h3, 4'h0);
    tick();
    expect_val(SIG_OUT, 2, "uf_out2");
    expect_val(SIG_ERR, 0, "uf_err0");
    drive(4'h0, 4'hF);
    tick();
    expect_val(SIG_OUT, 0, "uf_clamp");
    expect_val(SIG_ERR, 1, "uf_err1");
    drive(4'h0, 4'h0);
    ticks(10);
    expect_val(SIG_STATE, 3, "uf_drain");
    expect_val(SIG_ERR, 1, "uf_err_sticky");
    tick();
    expect_val(SIG_STATE, 4, "uf_min_drain");
    expect_val(SIG_TS, 13, "uf_ts");

    // Restart clears error; reset mid-DRAIN overrides start and abort
    do_start();
    expect_val(SIG_ERR, 0, "rs_err_clr");
    i_src_empty = 4'hE;
    ticks(12);
    expect_val(SIG_STATE, 3, "rd_drain");
    ticks(2);
    expect_val(SIG_TS, 14, "rd_ts");
    reset_n = 1'b0; i_start = 1'b1; i_abort = 1'b1;
    tick();
    expect_val(SIG_STATE, 0, "rd_state");
    expect_val(SIG_TS, 0, "rd_ts0");
    expect_val(SIG_SRCEN, 0, "rd_srcen");
    expect_val(SIG_MEAS, 0, "rd_meas");
    expect_val(SIG_DONE, 0, "rd_done");
    expect_val(SIG_ERR, 0, "rd_err");
    reset_n = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_src_empty = 4'hF;
    tick();
    expect_val(SIG_STATE, 0, "rd_idle");

    // Start and abort together in IDLE: abort wins
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    expect_val(SIG_STATE, 0, "ab_idle_both");
    i_start = 1'b0; i_abort = 1'b0;

    // Abort on MEASURE cycle 3 with start asserted
    do_start();
    ticks(4);
    drive(4'h1, 4'h0);
    ticks(3);
    drive(4'hF, 4'h0);
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    expect_val(SIG_STATE, 0, "ab_state");
    expect_val(SIG_SRCEN, 0, "ab_srcen");
    expect_val(SIG_MEAS, 0, "ab_meas");
    expect_val(SIG_INJ, 3, "ab_inj_held");
    expect_val(SIG_OUT, 3, "ab_out_held");
    expect_val(SIG_TS, 7, "ab_ts_held");
    i_abort = 1'b0; i_start = 1'b0;
    drive(4'h0, 4'h0);
    ticks(2);
    expect_val(SIG_STATE, 0, "ab_no_restart");
    expect_val(SIG_INJ, 3, "ab_inj_still");
    expect_val(SIG_TS, 7, "ab_ts_still");

    ticks(2);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

endmodule
